// File: rtl/axi_lite_req_arbiter.sv
// axi_lite_req_arbiter
//   Round-robin scheduler sharing one AXI4-Lite master port among NUM_REQ
//   register requesters. Each requester posts one read or write and holds
//   req_valid until its single-cycle req_done pulse. The block performs one
//   transaction at a time, sequencing AW/W/B or AR/R. Any wait state that
//   lasts TIMEOUT_CYC cycles is aborted and returns resp 2'b10.
//
// Ports
//   axi_clk, axi_rst_n        clock, synchronous active-low reset
//   req_valid/req_write       per-requester request and direction (1=write)
//   req_addr/req_wdata        packed 32-bit slices, slice i = [32i+31:32i]
//   req_done                  one-hot completion pulse
//   req_rdata/req_resp        completion data/response, held until next done
//   m_axi_*                   AXI4-Lite master port (prot=0, wstrb=F)
module axi_lite_req_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                   axi_clk,
  input  logic                   axi_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [31:0]            req_rdata,
  output logic [1:0]             req_resp,
  output logic [31:0]            m_axi_awaddr,
  output logic [2:0]             m_axi_awprot,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [31:0]            m_axi_wdata,
  output logic [3:0]             m_axi_wstrb,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  output logic [31:0]            m_axi_araddr,
  output logic [2:0]             m_axi_arprot,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [31:0]            m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_RESP,
    R_ADDR,
    R_DATA,
    DONE
  } state_t;

  state_t         state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  grant;
  logic [CW-1:0]  tmo_cnt;

  logic           arb_hit;
  logic [IW-1:0]  arb_idx;
  logic [IW-1:0]  cand;
  logic [31:0]    sel_addr;
  logic [31:0]    sel_wdata;
  logic           aw_pend;
  logic           w_pend;
  logic           progress;
  logic           abort;

  assign m_axi_awprot = '0;
  assign m_axi_arprot = '0;
  assign m_axi_wstrb  = '1;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                             input int unsigned   off);
    int unsigned s;
    s = 32'(base) + off;
    s = s % NUM_REQ;
    return IW'(s);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] g);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // First pending request at or above the round-robin pointer, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = wrap_idx(rr_ptr, i);
      if (!arb_hit && req_valid[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign sel_addr  = req_addr[32*arb_idx +: 32];
  assign sel_wdata = req_wdata[32*arb_idx +: 32];

  // Each write channel stays pending until its own handshake.
  assign aw_pend = m_axi_awvalid & ~m_axi_awready;
  assign w_pend  = m_axi_wvalid  & ~m_axi_wready;

  always_comb begin
    progress = 1'b0;
    case (state)
      W_ADDR:  progress = ~aw_pend & ~w_pend;
      W_RESP:  progress = m_axi_bvalid;
      R_ADDR:  progress = m_axi_arready;
      R_DATA:  progress = m_axi_rvalid;
      default: progress = 1'b0;
    endcase
  end

  // A wait state that cannot finish this edge and has used its budget aborts;
  // a handshake landing on the final cycle still completes normally.
  assign abort = (state inside {W_ADDR, W_RESP, R_ADDR, R_DATA}) &&
                 !progress && (tmo_cnt == TMO_LAST);

  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      tmo_cnt       <= '0;
      req_done      <= '0;
      req_rdata     <= '0;
      req_resp      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      req_done <= '0;
      if (abort) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        req_done      <= onehot(grant);
        req_rdata     <= '0;
        req_resp      <= 2'b10;
        tmo_cnt       <= '0;
        state         <= DONE;
      end else begin
        case (state)
          IDLE: begin
            tmo_cnt <= '0;
            if (arb_hit) begin
              grant <= arb_idx;
              if (req_write[arb_idx]) begin
                m_axi_awaddr  <= sel_addr;
                m_axi_wdata   <= sel_wdata;
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
                state         <= W_ADDR;
              end else begin
                m_axi_araddr  <= sel_addr;
                m_axi_arvalid <= 1'b1;
                state         <= R_ADDR;
              end
            end
          end
          W_ADDR: begin
            m_axi_awvalid <= aw_pend;
            m_axi_wvalid  <= w_pend;
            if (progress) begin
              m_axi_bready <= 1'b1;
              tmo_cnt      <= '0;
              state        <= W_RESP;
            end else begin
              tmo_cnt <= tmo_cnt + CW'(1);
            end
          end
          W_RESP: begin
            if (progress) begin
              m_axi_bready <= 1'b0;
              req_done     <= onehot(grant);
              req_rdata    <= '0;
              req_resp     <= m_axi_bresp;
              tmo_cnt      <= '0;
              state        <= DONE;
            end else begin
              tmo_cnt <= tmo_cnt + CW'(1);
            end
          end
          R_ADDR: begin
            if (progress) begin
              m_axi_arvalid <= 1'b0;
              m_axi_rready  <= 1'b1;
              tmo_cnt       <= '0;
              state         <= R_DATA;
            end else begin
              tmo_cnt <= tmo_cnt + CW'(1);
            end
          end
          R_DATA: begin
            if (progress) begin
              m_axi_rready <= 1'b0;
              req_done     <= onehot(grant);
              req_rdata    <= m_axi_rdata;
              req_resp     <= m_axi_rresp;
              tmo_cnt      <= '0;
              state        <= DONE;
            end else begin
              tmo_cnt <= tmo_cnt + CW'(1);
            end
          end
          DONE: begin
            rr_ptr  <= wrap_idx(grant, 1);
            tmo_cnt <= '0;
            state   <= IDLE;
          end
          default: begin
            tmo_cnt <= '0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// tb_axi_lite_req_arbiter
//   Directed bench for axi_lite_req_arbiter (4 requesters, short timeout).
//   A table of single transactions plus hand-written sequences for
//   simultaneous posting, fairness, channel skew, timeout and reset.
module tb_axi_lite_req_arbiter;

  localparam int NR  = 4;
  localparam int TO  = 16;
  localparam int BUD = 64;

  logic             axi_clk;
  logic             axi_rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*32-1:0] req_addr;
  logic [NR*32-1:0] req_wdata;
  logic [NR-1:0]    req_done;
  logic [31:0]      req_rdata;
  logic [1:0]       req_resp;
  logic [31:0]      m_axi_awaddr;
  logic [2:0]       m_axi_awprot;
  logic             m_axi_awvalid;
  logic             m_axi_awready;
  logic [31:0]      m_axi_wdata;
  logic [3:0]       m_axi_wstrb;
  logic             m_axi_wvalid;
  logic             m_axi_wready;
  logic [1:0]       m_axi_bresp;
  logic             m_axi_bvalid;
  logic             m_axi_bready;
  logic [31:0]      m_axi_araddr;
  logic [2:0]       m_axi_arprot;
  logic             m_axi_arvalid;
  logic             m_axi_arready;
  logic [31:0]      m_axi_rdata;
  logic [1:0]       m_axi_rresp;
  logic             m_axi_rvalid;
  logic             m_axi_rready;

  axi_lite_req_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .axi_clk(axi_clk), .axi_rst_n(axi_rst_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial begin
    axi_clk = 1'b0;
    forever #5 axi_clk = ~axi_clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [NR-1:0] done;
    logic [NR-1:0] done_after;
    logic [31:0]   rdata;
    logic [1:0]    resp;
    int            done_cyc;
    logic [31:0]   awaddr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [2:0]    awprot;
    logic [31:0]   araddr;
    logic [2:0]    arprot;
    int            aw_drop;
    int            w_drop;
    int            b_rise;
    int            b_high;
    bit            quiet;
  } obs_t;

  obs_t o;

  typedef struct {
    int            idx;
    bit            wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   s_rdata;
    logic [1:0]    s_resp;
    logic [NR-1:0] exp_done;
    logic [31:0]   exp_rdata;
    logic [1:0]    exp_resp;
  } vec_t;

  vec_t vecs[4];

  task automatic post(input int idx, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd);
    req_write[idx]            = wr;
    req_addr[32*idx +: 32]    = addr;
    req_wdata[32*idx +: 32]   = wd;
    req_valid[idx]            = 1'b1;
  endtask

  task automatic slave_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp   = 2'b00; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_rdata   = '0;    m_axi_rresp = 2'b00;
  endtask

  // Responsive slave for one transaction; stops one cycle after req_done.
  // Observation index n counts falling edges since the call.
  task automatic service(input int aw_lat, input int w_lat, input bit hang_b,
                         input logic [31:0] s_rdata, input logic [1:0] s_resp);
    int aw_cnt, w_cnt;
    bit got, seen_aw, seen_ar, p_aw, p_w, p_b;
    aw_cnt = 0; w_cnt = 0; got = 0; seen_aw = 0; seen_ar = 0;
    p_aw = 0; p_w = 0; p_b = 0;
    o.done = '0; o.done_after = '0; o.rdata = '0; o.resp = '0; o.done_cyc = -1;
    o.awaddr = '0; o.wdata = '0; o.wstrb = '0; o.awprot = '1; o.araddr = '0;
    o.arprot = '1; o.aw_drop = -1; o.w_drop = -1; o.b_rise = -1; o.b_high = 0;
    o.quiet = 0;
    slave_idle();
    for (int n = 1; n <= BUD && !got; n++) begin
      @(negedge axi_clk);
      if (m_axi_awvalid && !seen_aw) begin
        seen_aw = 1; o.awaddr = m_axi_awaddr; o.wdata = m_axi_wdata;
        o.wstrb = m_axi_wstrb; o.awprot = m_axi_awprot;
      end
      if (m_axi_arvalid && !seen_ar) begin
        seen_ar = 1; o.araddr = m_axi_araddr; o.arprot = m_axi_arprot;
      end
      if (p_aw && !m_axi_awvalid) o.aw_drop = n;
      if (p_w && !m_axi_wvalid)   o.w_drop  = n;
      if (!p_b && m_axi_bready)   o.b_rise  = n;
      if (m_axi_bready) o.b_high++;
      p_aw = m_axi_awvalid; p_w = m_axi_wvalid; p_b = m_axi_bready;
      if (req_done != '0) begin
        got = 1; o.done = req_done; o.rdata = req_rdata; o.resp = req_resp;
        o.done_cyc = n;
        o.quiet = !(m_axi_awvalid | m_axi_wvalid | m_axi_bready |
                    m_axi_arvalid | m_axi_rready);
        req_valid = req_valid & ~req_done;
      end
      m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_lat);
      if (m_axi_awvalid) aw_cnt++;
      m_axi_wready  = m_axi_wvalid && (w_cnt >= w_lat);
      if (m_axi_wvalid) w_cnt++;
      m_axi_arready = m_axi_arvalid;
      m_axi_bvalid  = m_axi_bready && !hang_b;
      m_axi_bresp   = m_axi_bvalid ? s_resp : 2'b00;
      m_axi_rvalid  = m_axi_rready;
      m_axi_rdata   = m_axi_rvalid ? s_rdata : '0;
      m_axi_rresp   = m_axi_rvalid ? s_resp : 2'b00;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done: no req_done within %0d cycles", BUD);
    end
    @(negedge axi_clk);
    o.done_after = req_done;
    slave_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int order[6];

  initial begin
    vecs[0] = '{0, 1'b1, 32'h0000_0003, 32'hDEAD_BEEF, 32'h0,         2'b00,
                4'b0001, 32'h0,         2'b00};
    vecs[1] = '{2, 1'b0, 32'h0000_0005, 32'h0,         32'h1234_5678, 2'b00,
                4'b0100, 32'h1234_5678, 2'b00};
    vecs[2] = '{1, 1'b0, 32'h1000_0004, 32'h0,         32'hCAFE_F00D, 2'b01,
                4'b0010, 32'hCAFE_F00D, 2'b01};
    vecs[3] = '{3, 1'b1, 32'h0000_0040, 32'h0000_A5A5, 32'h0,         2'b11,
                4'b1000, 32'h0,         2'b11};
    order = '{0, 1, 2, 3, 0, 1};

    axi_rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    slave_idle();
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);

    // Reset state
    chk("rst_done",   64'(req_done), 64'h0);
    chk("rst_rdata",  64'(req_rdata), 64'h0);
    chk("rst_resp",   64'(req_resp), 64'h0);
    chk("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                           m_axi_arvalid, m_axi_rready}), 64'h0);
    chk("rst_addrs",  64'({m_axi_awaddr, m_axi_araddr}), 64'h0);
    chk("rst_wdata",  64'(m_axi_wdata), 64'h0);
    chk("rst_tieoff", 64'({m_axi_wstrb, m_axi_awprot, m_axi_arprot}), 64'hF << 6);
    axi_rst_n = 1'b1;

    // Requests 0 and 2 posted together right after reset: 0 first.
    post(0, 1'b0, 32'h10, 32'h0);
    post(2, 1'b0, 32'h20, 32'h0);
    service(0, 0, 0, 32'h0000_0A0A, 2'b00);
    chk("simul_first",  64'(o.done), 64'b0001);
    service(0, 0, 0, 32'h0000_0B0B, 2'b00);
    chk("simul_second", 64'(o.done), 64'b0100);
    chk("simul_rdata",  64'(o.rdata), 64'h0000_0B0B);

    // Table of single transactions
    for (int v = 0; v < 4; v++) begin
      post(vecs[v].idx, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      service(0, 0, 0, vecs[v].s_rdata, vecs[v].s_resp);
      chk($sformatf("vec%0d_done", v),  64'(o.done),  64'(vecs[v].exp_done));
      chk($sformatf("vec%0d_rdata", v), 64'(o.rdata), 64'(vecs[v].exp_rdata));
      chk($sformatf("vec%0d_resp", v),  64'(o.resp),  64'(vecs[v].exp_resp));
      chk($sformatf("vec%0d_pulse", v), 64'(o.done_after), 64'h0);
      if (vecs[v].wr) begin
        chk($sformatf("vec%0d_awaddr", v), 64'(o.awaddr), 64'(vecs[v].addr));
        chk($sformatf("vec%0d_wdata", v),  64'(o.wdata),  64'(vecs[v].wdata));
        chk($sformatf("vec%0d_wstrb", v),  64'({o.wstrb, o.awprot}), 64'h78);
      end else begin
        chk($sformatf("vec%0d_araddr", v), 64'(o.araddr), 64'(vecs[v].addr));
        chk($sformatf("vec%0d_arprot", v), 64'(o.arprot), 64'h0);
      end
    end

    // Fairness: all four requesting, 0 and 1 re-post once.
    for (int i = 0; i < NR; i++) post(i, 1'b0, 32'(i * 4), 32'h0);
    for (int k = 0; k < 6; k++) begin
      service(0, 0, 0, 32'h100 + 32'(k), 2'b00);
      chk($sformatf("rr_grant%0d", k), 64'(o.done), 64'(1) << order[k]);
      chk($sformatf("rr_rdata%0d", k), 64'(o.rdata), 64'h100 + 64'(k));
      if (k < 2) req_valid[order[k]] = 1'b1;
    end

    // Channel skew: W handshake 3 cycles before AW, then the reverse.
    post(2, 1'b1, 32'h44, 32'h1111_2222);
    service(3, 0, 0, 32'h0, 2'b00);
    chk("skewA_w_drop",  64'(o.w_drop),  64'd2);
    chk("skewA_aw_drop", 64'(o.aw_drop), 64'd5);
    chk("skewA_b_rise",  64'(o.b_rise),  64'd5);
    chk("skewA_done",    64'(o.done),    64'b0100);
    post(3, 1'b1, 32'h48, 32'h3333_4444);
    service(0, 3, 0, 32'h0, 2'b00);
    chk("skewB_aw_drop", 64'(o.aw_drop), 64'd2);
    chk("skewB_w_drop",  64'(o.w_drop),  64'd5);
    chk("skewB_b_rise",  64'(o.b_rise),  64'd5);
    chk("skewB_done",    64'(o.done),    64'b1000);

    // Timeout in W_RESP with a read queued behind it.
    post(0, 1'b1, 32'h80, 32'h5555_AAAA);
    post(1, 1'b0, 32'h84, 32'h0);
    service(0, 0, 1, 32'h0, 2'b00);
    chk("tmo_done",   64'(o.done), 64'b0001);
    chk("tmo_resp",   64'(o.resp), 64'h2);
    chk("tmo_rdata",  64'(o.rdata), 64'h0);
    chk("tmo_quiet",  64'(o.quiet), 64'h1);
    chk("tmo_bhigh",  64'(o.b_high), 64'(TO));
    chk("tmo_length", 64'(o.done_cyc - o.b_rise), 64'(TO));
    service(0, 0, 0, 32'h0BAD_F00D, 2'b00);
    chk("tmo_next_done",  64'(o.done),  64'b0010);
    chk("tmo_next_rdata", 64'(o.rdata), 64'h0BAD_F00D);
    chk("tmo_next_resp",  64'(o.resp),  64'h0);

    // Reset during R_DATA; pointer is 2 beforehand, 1 and 3 pending.
    post(2, 1'b0, 32'h2000_0008, 32'h0);
    begin
      bit in_rdata;
      in_rdata = 0;
      for (int c = 0; c < 8 && !in_rdata; c++) begin
        @(negedge axi_clk);
        m_axi_arready = m_axi_arvalid;
        if (m_axi_rready) in_rdata = 1;
      end
      m_axi_arready = 1'b0;
      chk("mid_reached_rdata", 64'(in_rdata), 64'h1);
    end
    post(1, 1'b0, 32'h2000_0010, 32'h0);
    post(3, 1'b0, 32'h2000_0018, 32'h0);
    axi_rst_n = 1'b0;
    @(negedge axi_clk);
    chk("mid_rst_done",   64'(req_done), 64'h0);
    chk("mid_rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                               m_axi_arvalid, m_axi_rready}), 64'h0);
    chk("mid_rst_araddr", 64'(m_axi_araddr), 64'h0);
    chk("mid_rst_rdata",  64'(req_rdata), 64'h0);
    axi_rst_n = 1'b1;
    req_valid[2] = 1'b0;
    service(0, 0, 0, 32'h7777_0001, 2'b00);
    chk("post_rst_grant", 64'(o.done), 64'b0010);
    chk("post_rst_addr",  64'(o.araddr), 64'h2000_0010);
    service(0, 0, 0, 32'h7777_0003, 2'b00);
    chk("post_rst_next",  64'(o.done), 64'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
- Round-robin scheduler that shares one AXI4-Lite master port among NUM_REQ PL-side register requesters.
- Its master port drives the PS/PL register bridge slave.
- Each requester posts a single read or write and gets a one-cycle completion with data and response.
- Serialises accesses, sequences the AW/W/B and AR/R channels, and aborts hung transactions on a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 1024, cycles allowed in any wait state before abort (≥4).

Ports:
- axi_clk  in  1  sole clock; all logic on its rising edge.
- axi_rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request; held high until req_done for that index.
- req_write  in  NUM_REQ  1=write, 0=read; stable while req_valid is high.
- req_addr  in  NUM_REQ*32  packed addresses; slice i = bits [32i+31:32i].
- req_wdata  in  NUM_REQ*32  packed write data.
- req_done  out  NUM_REQ  one-hot single-cycle completion pulse.
- req_rdata  out  32  read data; valid while req_done is nonzero.
- req_resp  out  2  AXI response; 2'b10 on timeout.
- m_axi_awaddr  out  32
- m_axi_awprot  out  3  tied 3'b000
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32
- m_axi_wstrb  out  4  tied 4'hF
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- m_axi_araddr  out  32
- m_axi_arprot  out  3  tied 3'b000
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  32
- m_axi_rresp  in  2
- m_axi_rvalid  in  1
- m_axi_rready  out  1

Behaviour:
- **Reset** (axi_rst_n=0 at an edge): state=IDLE. All valid/ready outputs, req_done, req_rdata, req_resp, addresses and wdata are 0. RR pointer=0; timeout counter=0.
- Reset mid-transaction abandons the transaction; no req_done is issued for it.
- **States**: IDLE, W_ADDR, W_RESP, R_ADDR, R_DATA, DONE.
- **IDLE arbitration**: if any req_valid is set, grant the first set index scanning from the RR pointer upward, wrapping modulo NUM_REQ.
  - Latch that slice's addr, wdata and write flag.
  - Write: go to W_ADDR and assert awvalid and wvalid at the same edge.
  - Read: go to R_ADDR and assert arvalid.
  - The AXI valid therefore rises the cycle after the request is sampled.
- **W_ADDR**: awvalid drops on the edge where awvalid&awready; wvalid drops independently on wvalid&wready. Both may complete in the same edge. When both are complete, go to W_RESP with bready=1.
- **W_RESP**: bready is held high. On bvalid, capture bresp, drop bready and go to DONE.
- **R_ADDR**: arvalid drops on arready and the block goes to R_DATA with rready=1.
- **R_DATA**: rready is held high for the whole state (the slave may gate rvalid on rready). On rvalid, capture rdata/rresp, drop rready and go to DONE.
- **DONE** (exactly one cycle):
  - req_done[grant]=1 with req_rdata/req_resp. req_rdata=0 for writes.
  - RR pointer = (grant+1) mod NUM_REQ.
  - Next state is IDLE.
  - req_done is 0 in every other state. req_rdata/req_resp hold their values until the next DONE.
- **Requester rule**: req_valid drops at the edge where req_done is sampled high. IDLE therefore never re-grants a finished request.
- **Timeout**: the counter clears on every state change and increments in W_ADDR, W_RESP, R_ADDR and R_DATA. On reaching TIMEOUT_CYC-1:
  - all AXI valid/ready outputs drop at that edge;
  - the block goes to DONE with req_resp=2'b10 and req_rdata=0.
- Requests arriving while busy simply wait; there is no queue beyond req_valid itself.
- Non-granted requests are never dropped. Worst-case wait is NUM_REQ-1 transactions.

Test Plan:
- **Single write**: req 0 writes addr 3, data 0xDEADBEEF → awaddr=3, wdata=0xDEADBEEF, wstrb=F, prot=0. req_done=4'b0001 for one cycle after bvalid, resp=0.
- **Single read**: req 2 reads addr 5 and the slave returns 0x12345678 → araddr=5, rready high until rvalid. req_done=4'b0100 with rdata=0x12345678, resp=0.
- **Fairness**: all four requesters continuously requesting → grant order 0,1,2,3,0,1. Requests 0 and 2 posted simultaneously from reset → 0 served first, then 2.
- **Channel skew**: wready asserted 3 cycles before awready, then the reverse → in both cases W_RESP is entered only after both handshakes, with each valid dropping at its own handshake.
- **Timeout**: slave never asserts bvalid → after TIMEOUT_CYC cycles in W_RESP, bready=0, req_done pulses with resp=2'b10. The next queued request then proceeds normally.
- **Reset mid-operation**: axi_rst_n low during R_DATA → next edge all outputs 0, state IDLE, no req_done. After release, pending req 1 is granted first from pointer 0.
